// File: rtl/miriscv_uart_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_uart_pkg
// Shared definitions for the MIRISCV UART transmitter.
//   UART_DATA_BITS   : payload bits per frame
//   UART_START_BIT   : line level of the start bit
//   UART_STOP_BIT    : line level of the stop bit (also the idle level)
//   uart_tx_state_e  : transmitter FSM state encoding
// Optional feature macro: MIRISCV_UART_TX_PARITY_EN adds the even-parity state.
// -----------------------------------------------------------------------------
package miriscv_uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   // Encodings are fixed so that waveforms and external probes stay stable
   // whether or not the parity state is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef MIRISCV_UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_tx_state_e;

   // Even parity: the parity bit makes the total number of ones even.
   function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/miriscv_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// miriscv_uart_tx_fifo
// Synchronous single-clock FIFO buffering bytes for the UART transmitter.
// Read data is presented combinationally from the head entry (show-ahead).
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, empties the FIFO
//   push_i  : write data_i (ignored when full)
//   data_i  : write data
//   pop_i   : discard head entry (ignored when empty)
//   data_o  : head entry, valid while !empty_o
//   full_o  : no free entry
//   empty_o : no stored entry
// -----------------------------------------------------------------------------
module miriscv_uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count == (PTR_W + 1)'(DEPTH));
   assign empty_o = (count == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only read after it was written,
   // and leaving it unreset lets it map onto plain RAM/flops without reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/miriscv_uart_tx.sv
// -----------------------------------------------------------------------------
// miriscv_uart_tx
// UART transmitter with a small byte FIFO. Frame: start(0), 8 data bits LSB
// first, optional even parity, one stop bit(1). Each bit lasts
// DIV = CLK_FREQ_HZ/BAUDRATE clock cycles. Frames queued in the FIFO are sent
// back-to-back without idle time.
// Configuration macro: MIRISCV_UART_TX_PARITY_EN -> 8E1 (11*DIV cycles/frame);
// undefined (default) -> 8N1 (10*DIV cycles/frame).
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset; aborts the frame, drops the FIFO
//   data_i  : byte to transmit
//   valid_i : data_i valid; accepted when valid_i && ready_o
//   ready_o : FIFO can accept a byte
//   tx_o    : registered serial line, idle high
//   busy_o  : frame in progress or FIFO non-empty
// -----------------------------------------------------------------------------
module miriscv_uart_tx
   import miriscv_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUDRATE    = 6250000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [UART_DATA_BITS-1:0] data_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic                      tx_o,
   output logic                      busy_o
);

   localparam int DIV   = CLK_FREQ_HZ / BAUDRATE;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_bad_div
      $error("miriscv_uart_tx: CLK_FREQ_HZ/BAUDRATE must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("miriscv_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
   end

   uart_tx_state_e            state;
   logic [CNT_W-1:0]          baud_cnt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      tx_q;
`ifdef MIRISCV_UART_TX_PARITY_EN
   logic                      parity_q;
`endif

   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_data;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      baud_end;

   // ready_o depends only on the FIFO level (and reset), never on a pop in
   // the same cycle, so the upstream handshake has no path through the FSM.
   assign ready_o   = !fifo_full && !rst_i;
   assign fifo_push = valid_i && ready_o;
   assign baud_end  = (baud_cnt == CNT_W'(DIV - 1));

   // A frame starts from IDLE or straight out of the last stop-bit cycle;
   // the byte always passes through the FIFO first.
   assign fifo_pop  = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

   assign tx_o   = tx_q;
   assign busy_o = (state != ST_IDLE) || !fifo_empty;

   miriscv_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (data_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
         tx_q     <= UART_STOP_BIT;
`ifdef MIRISCV_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (fifo_pop) begin
         // Load the next byte and begin its start bit.
         state    <= ST_START;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= fifo_data;
         tx_q     <= UART_START_BIT;
`ifdef MIRISCV_UART_TX_PARITY_EN
         parity_q <= uart_even_parity(fifo_data);
`endif
      end else begin
         baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               tx_q     <= UART_STOP_BIT;
            end
            ST_START: begin
               if (baud_end) begin
                  state <= ST_DATA;
                  tx_q  <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (baud_end) begin
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                     bit_idx <= '0;
`ifdef MIRISCV_UART_TX_PARITY_EN
                     state   <= ST_PARITY;
                     tx_q    <= parity_q;
`else
                     state   <= ST_STOP;
                     tx_q    <= UART_STOP_BIT;
`endif
                  end else begin
                     // shift_q[0] is on the line; present the next bit.
                     bit_idx <= bit_idx + 1'b1;
                     shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                     tx_q    <= shift_q[1];
                  end
               end
            end
`ifdef MIRISCV_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_end) begin
                  state <= ST_STOP;
                  tx_q  <= UART_STOP_BIT;
               end
            end
`endif
            ST_STOP: begin
               // A non-empty FIFO is handled by the pop branch above.
               if (baud_end) begin
                  state <= ST_IDLE;
                  tx_q  <= UART_STOP_BIT;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_q  <= UART_STOP_BIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_miriscv_uart_tx
// Scoreboard bench for miriscv_uart_tx (100 MHz clock, 6.25 Mbaud, DIV=16).
// Accepted bytes are queued as expected frames; a monitor decodes tx_o and
// compares every sample of every frame bit. Frame length follows
// MIRISCV_UART_TX_PARITY_EN (176 cycles 8E1, otherwise 160 cycles 8N1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_miriscv_uart_tx;

   localparam int DIV = 16;
`ifdef MIRISCV_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   logic       clk_i   = 1'b0;
   logic       rst_i   = 1'b1;
   logic [7:0] data_i  = 8'h00;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic       tx_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int frames_started = 0;
   int frames_done    = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];

   miriscv_uart_tx #(
      .CLK_FREQ_HZ (100000000),
      .BAUDRATE    (6250000),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .tx_o    (tx_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Present a byte and hold valid_i until it is accepted. Called just after
   // a clock edge; returns just after the accepting edge with valid_i still high.
   task automatic push_byte(input logic [7:0] b, input bit expect_tx, output int acc);
      int n;
      data_i  = b;
      valid_i = 1'b1;
      n = 0;
      while (!ready_o && n < 400) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("push_ready", ready_o, 1'b1);
      @(posedge clk_i); #1;
      acc = cyc;
      if (expect_tx) exp_q.push_back(b);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk_i);
   endtask

   // Monitor: decode each frame sample by sample against the scoreboard.
   initial begin : monitor
      logic [7:0] exp_b;
      logic [7:0] got_b;
      logic       bits [11];
      int         bad;
      bit         aborted;
      forever begin
         @(negedge clk_i);
         if (!rst_i && tx_o === 1'b0) begin
            frames_started++;
            start_q.push_back(cyc);
            check("sb_has_expected", exp_q.size() != 0, 1'b1);
            exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = exp_b[i];
            bits[9]  = ^exp_b;
            bits[NBITS-1] = 1'b1;
            bad = 0;
            got_b = 8'h00;
            aborted = 1'b0;
            for (int b = 0; b < NBITS; b++) begin
               for (int c = 0; c < DIV; c++) begin
                  if (!aborted) begin
                     if (b != 0 || c != 0) @(negedge clk_i);
                     if (rst_i) aborted = 1'b1;
                     else begin
                        if (tx_o !== bits[b]) bad++;
                        if (c == DIV / 2 && b >= 1 && b <= 8) got_b[b-1] = tx_o;
                     end
                  end
               end
            end
            if (!aborted) begin
               check("frame_data", got_b, exp_b);
               check("frame_bad_samples", bad, 0);
               frames_done++;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int a;
      int acc [5];
      int viol;
      int fs;
      logic [7:0] burst [5];
      burst[0] = 8'h43; burst[1] = 8'h6F; burst[2] = 8'h72;
      burst[3] = 8'h65; burst[4] = 8'h0A;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_tx", tx_o, 1'b1);
      check("rst_ready", ready_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", ready_o, 1'b1);
      check("post_rst_busy", busy_o, 1'b0);
      check("post_rst_tx", tx_o, 1'b1);
      #1;

      // Single byte 0x43: start one cycle after accept, busy falls after frame
      push_byte(8'h43, 1'b1, a);
      valid_i = 1'b0;
      wait_cyc(a + 1);
      check("single_tx_low", tx_o, 1'b0);
      check("single_busy", busy_o, 1'b1);
      wait_cyc(a + FRAME);
      check("single_stop_busy", busy_o, 1'b1);
      check("single_stop_tx", tx_o, 1'b1);
      @(negedge clk_i);
      check("single_done_busy", busy_o, 1'b0);
      check("single_done_tx", tx_o, 1'b1);
      check("single_frames", frames_done, 1);
      check("single_start_cnt", start_q.size(), 1);
      if (start_q.size() != 0) check("single_start_cyc", start_q.pop_front(), a + 1);
      #1;

      // Burst "Core\n" with valid_i held high
      for (int i = 0; i < 5; i++) push_byte(burst[i], 1'b1, acc[i]);
      valid_i = 1'b0;
      for (int i = 1; i < 5; i++) check("burst_accept_cyc", acc[i], acc[0] + i);
      a = acc[0];
      @(negedge clk_i);
      check("burst_full_ready", ready_o, 1'b0);
      wait_cyc(a + 1 + FRAME);
      check("burst_ready_again", ready_o, 1'b1);
      viol = 0;
      while (cyc < a + 5 * FRAME) begin
         @(negedge clk_i);
         if (!busy_o) viol++;
      end
      check("burst_busy_gap", viol, 0);
      @(negedge clk_i);
      check("burst_done_busy", busy_o, 1'b0);
      check("burst_frames", frames_done, 6);
      check("burst_start_cnt", start_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (start_q.size() != 0) check("burst_start_cyc", start_q.pop_front(), a + 1 + i * FRAME);
      #1;

      // Reset during data bit 3 of 0xA5 with two more bytes queued
      push_byte(8'hA5, 1'b1, a);
      push_byte(8'h11, 1'b0, fs);
      push_byte(8'h22, 1'b0, fs);
      valid_i = 1'b0;
      wait_cyc(a + 70);
      check("abort_bit3_tx", tx_o, 1'b0);
      check("abort_busy_before", busy_o, 1'b1);
      #1 rst_i = 1'b1;
      @(negedge clk_i);
      check("abort_tx", tx_o, 1'b1);
      check("abort_busy", busy_o, 1'b0);
      check("abort_ready_in_rst", ready_o, 1'b0);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("abort_ready_after", ready_o, 1'b1);
      fs = frames_started;
      viol = 0;
      repeat (400) begin
         @(negedge clk_i);
         if (tx_o !== 1'b1 || busy_o !== 1'b0) viol++;
      end
      check("abort_line_quiet", viol, 0);
      check("abort_no_new_frames", frames_started, fs);
      check("abort_sb_empty", exp_q.size(), 0);
      check("abort_start_cyc", start_q.size() != 0 ? start_q.pop_front() : -1, a + 1);
      start_q.delete();
      #1;

      // 0xFF then 0x00 back-to-back (all-ones / all-zeros payloads)
      push_byte(8'hFF, 1'b1, a);
      push_byte(8'h00, 1'b1, fs);
      valid_i = 1'b0;
      wait_cyc(a + 2 * FRAME + 1);
      check("ff00_busy_done", busy_o, 1'b0);
      check("ff00_frames", frames_done, 8);
      check("ff00_start_cnt", start_q.size(), 2);
      for (int i = 0; i < 2; i++)
         if (start_q.size() != 0) check("ff00_start_cyc", start_q.pop_front(), a + 1 + i * FRAME);
      check("final_sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
